dbf_chan_interp: RTL

// - Parametrised single-channel digital-beamforming delay/weight stage.
// - Data path: coarse delay (sample ring buffer) -> fine delay (linear

---
 rtl/dbf_chan_interp.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dbf_chan_interp.sv
// dbf_chan_interp: one DBF element -- ring-buffer coarse delay, linear fine delay,
// apodisation weight, shifted output. Define DBF_ROUND_SAT_EN for round-half-up + saturation.
module dbf_chan_interp #(
  parameter int unsigned IN_WD     = 16,
  parameter int unsigned APO_WD    = 16,
  parameter int unsigned OUT_WD    = 16,
  parameter int unsigned OUT_SHIFT = 15,
  parameter int unsigned BUF_AW    = 9,
  parameter int unsigned LUT_AW    = 10,
  parameter int unsigned FRAC_WD   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        tx_en,
  input  logic signed [IN_WD-1:0]     ch_in,
  input  logic signed [APO_WD-1:0]    apo_din,
  input  logic                        lut_we,
  input  logic [LUT_AW-1:0]           lut_addr,
  input  logic [BUF_AW+FRAC_WD-1:0]   lut_wdata,
  output logic signed [OUT_WD-1:0]    dout,
  output logic                        dout_valid,
  output logic signed [IN_WD-1:0]     cd_dout,
  output logic                        sat_flag
);

  localparam int unsigned DEPTH     = 2**BUF_AW;
  localparam int unsigned LUT_DEPTH = 2**LUT_AW;
  localparam int unsigned LW        = BUF_AW + FRAC_WD;
  localparam int unsigned DIF_WD    = IN_WD + 1;
  localparam int unsigned DF_WD     = DIF_WD + FRAC_WD + 1;
  localparam int unsigned Y_WD      = IN_WD + 1;
  localparam int unsigned P_WD      = Y_WD + APO_WD;
  localparam logic [BUF_AW-1:0] D_MAX   = BUF_AW'(DEPTH - 2);
  localparam logic [BUF_AW:0]   CNT_MAX = (BUF_AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic   start_q, win_clr, accept, flush;
  logic [BUF_AW-1:0] wr_ptr;
  logic [BUF_AW:0]   cnt;
  logic [LUT_AW-1:0] lut_idx;
  logic [5:0]        v;

  logic signed [IN_WD-1:0] buf_mem [DEPTH];
  logic [LW-1:0]           lut_mem [LUT_DEPTH];

  logic signed [IN_WD-1:0]  s0_x;
  logic signed [APO_WD-1:0] s0_apo, s1_apo, s2_apo, s3_apo, s4_apo;
  logic [BUF_AW-1:0]        s0_ptr, s1_ptr;
  logic [BUF_AW:0]          s0_cnt, s1_cnt;
  logic [LUT_AW-1:0]        s0_k;
  logic [LW-1:0]            s1_dly;
  logic [BUF_AW-1:0]        d_int, d_cl, a0_c, a1_c;
  logic                     ok0_c, ok1_c;
  logic signed [IN_WD-1:0]  x0_c, x1_c, s2_x0, s2_x1, s3_x0;
  logic [FRAC_WD-1:0]       s2_f;
  logic signed [DIF_WD-1:0] diff_c;
  logic signed [DF_WD-1:0]  s3_df;
  logic signed [Y_WD-1:0]   s4_y;
  logic signed [P_WD-1:0]   s5_p;
  logic signed [OUT_WD-1:0] res_c;
  logic                     sat_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Window control: a rising start opens a window, any low start closes it and flushes
  always_comb begin
    state_d = state_q;
    win_clr = 1'b0;
    accept  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: if (start && !start_q) begin
        state_d = RUN;
        win_clr = 1'b1;
      end
      RUN: if (!start) begin
        state_d = IDLE;
        flush   = 1'b1;
      end else begin
        accept = !tx_en;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      wr_ptr     <= '0;
      cnt        <= '0;
      lut_idx    <= '0;
      v          <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cd_dout    <= '0;
      sat_flag   <= 1'b0;
    end else begin
      start_q    <= start;
      v          <= flush ? 6'b0 : {v[4:0], accept};
      dout_valid <= v[5] & ~flush;
      dout       <= (v[5] && !flush) ? res_c : '0;
      if (v[1] && !flush) cd_dout <= x0_c;
      if (win_clr) begin
        wr_ptr   <= '0;
        cnt      <= '0;
        lut_idx  <= '0;
        sat_flag <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr <= wr_ptr + BUF_AW'(1);
          if (cnt != CNT_MAX) cnt <= cnt + (BUF_AW+1)'(1);
          if (lut_idx != '1)  lut_idx <= lut_idx + LUT_AW'(1);
        end
        if (v[5] && !flush && sat_c) sat_flag <= 1'b1;
      end
    end
  end

  // Tap addressing; count masks taps that precede the first sample of the window
  always_comb begin
    d_int  = s1_dly[LW-1:FRAC_WD];
    d_cl   = (d_int > D_MAX) ? D_MAX : d_int;
    a0_c   = s1_ptr - d_cl;
    a1_c   = a0_c - BUF_AW'(1);
    ok0_c  = ({1'b0, d_cl} <= s1_cnt);
    ok1_c  = ({1'b0, d_cl} <  s1_cnt);
    x0_c   = ok0_c ? buf_mem[a0_c] : '0;
    x1_c   = ok1_c ? buf_mem[a1_c] : '0;
    diff_c = DIF_WD'(s2_x1) - DIF_WD'(s2_x0);
  end

  // Datapath: capture, LUT rd + buffer write, buffer rd, diff*f, add, mul
  always_ff @(posedge clk) begin
    if (lut_we && state_q == IDLE) lut_mem[lut_addr] <= lut_wdata;
    if (v[0]) buf_mem[s0_ptr] <= s0_x;
    s0_x   <= ch_in;
    s0_apo <= apo_din;
    s0_ptr <= wr_ptr;
    s0_cnt <= cnt;
    s0_k   <= lut_idx;
    s1_dly <= lut_mem[s0_k];
    s1_ptr <= s0_ptr;
    s1_cnt <= s0_cnt;
    s1_apo <= s0_apo;
    s2_x0  <= x0_c;
    s2_x1  <= x1_c;
    s2_f   <= s1_dly[FRAC_WD-1:0];
    s2_apo <= s1_apo;
    s3_df  <= DF_WD'(diff_c) * DF_WD'($signed({1'b0, s2_f}));
    s3_x0  <= s2_x0;
    s3_apo <= s2_apo;
    s4_y   <= Y_WD'(s3_x0) + Y_WD'(s3_df >>> FRAC_WD);
    s4_apo <= s3_apo;
    s5_p   <= P_WD'(s4_y) * P_WD'(s4_apo);
  end

`ifdef DBF_ROUND_SAT_EN
  localparam int unsigned R_WD = P_WD + 1;
  localparam logic signed [R_WD-1:0] HALF  = R_WD'(2**(OUT_SHIFT-1));
  localparam logic signed [R_WD-1:0] MAX_V = R_WD'(2**(OUT_WD-1) - 1);
  localparam logic signed [R_WD-1:0] MIN_V = ~MAX_V;
  logic signed [R_WD-1:0] rnd_c;

  always_comb begin
    rnd_c = (R_WD'(s5_p) + HALF) >>> OUT_SHIFT;
    sat_c = 1'b0;
    res_c = rnd_c[OUT_WD-1:0];
    if (rnd_c > MAX_V) begin
      res_c = MAX_V[OUT_WD-1:0];
      sat_c = 1'b1;
    end else if (rnd_c < MIN_V) begin
      res_c = MIN_V[OUT_WD-1:0];
      sat_c = 1'b1;
    end
  end
`else
  always_comb begin
    sat_c = 1'b0;
    res_c = OUT_WD'(s5_p >>> OUT_SHIFT);
  end
`endif

endmodule
